// File: rtl/data_memory_responder_if.sv
// Processor data-port bus between a requester (master) and the data-memory responder (slave).
// MEM_ALIGN_CHECK_EN adds the resp_error response flag.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_address;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy, resp_error
    );
`else
    modport master (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed 64-bit data memory with programmable wait states and a ready/valid handshake.
// Optional MEM_ALIGN_CHECK_EN flags misaligned / out-of-range requests via resp_error.
module data_memory_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0]    idx_reg, req_idx, acc_idx;
    logic                    write_reg, err_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg, acc_wdata;
    logic                    req_err, acc_write, acc_err;
    logic                    accept, enter_resp;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_reg;
    logic                    rd_loaded_reg;

    assign req_idx = bus.req_address[ADDR_BITS+2:3];

`ifdef MEM_ALIGN_CHECK_EN
    assign req_err = (bus.req_address[2:0] != 3'b000) ||
                     (bus.req_address[63:ADDR_BITS+3] != '0);
`else
    logic unused_addr_bits;
    assign req_err          = 1'b0;
    assign unused_addr_bits = ^{bus.req_address[2:0], bus.req_address[63:ADDR_BITS+3]};
`endif

    assign accept = (state_reg == IDLE) && bus.req_valid;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the RAM access must take the live request instead of the captured one.
    assign acc_idx   = (state_reg == IDLE) ? req_idx           : idx_reg;
    assign acc_write = (state_reg == IDLE) ? bus.req_write     : write_reg;
    assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata     : wdata_reg;
    assign acc_err   = (state_reg == IDLE) ? req_err           : err_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_next = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            err_reg       <= 1'b0;
            wdata_reg     <= '0;
            rd_loaded_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= req_idx;
                write_reg <= bus.req_write;
                err_reg   <= req_err;
                wdata_reg <= bus.req_wdata;
            end
            if (enter_resp) begin
                rd_loaded_reg <= 1'b1;
            end
        end
    end

    // Block RAM: read-before-write on the RESP entry edge; contents are never reset.
    always_ff @(posedge clock) begin
        if (enter_resp) begin
            rd_word_reg <= acc_err ? '0 : mem[acc_idx];
            if (acc_write && !acc_err) begin
                mem[acc_idx] <= acc_wdata;
            end
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.resp_valid = (state_reg == RESP);
    // rd_loaded_reg masks the unreset RAM output register until the first response.
    assign bus.resp_rdata = rd_loaded_reg ? rd_word_reg : '0;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.resp_error = (state_reg == RESP) && err_reg;
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases, randomized traffic
// against an array reference model, and a zero-wait-state instance for streaming timing.
`timescale 1ns/1ps
module tb_data_memory_responder;
    localparam int AB    = 8;
    localparam int WS    = 2;
    localparam int DEPTH = 1 << AB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_memory_responder_if bus();
    data_memory_responder_if bus0();

    data_memory_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS), .DATA_WIDTH(64)) u_dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    data_memory_responder #(.ADDR_BITS(AB), .WAIT_STATES(0), .DATA_WIDTH(64)) u_dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] model  [DEPTH];
    logic [63:0] model0 [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [63:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (a[2:0] != 3'b000) || ((a >> (AB + 3)) != 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a >> 3) % 64'(DEPTH));
    endfunction

    // One complete transaction on the WAIT_STATES=2 instance; entered and left in IDLE at #1 after an edge.
    task automatic xact(input string tag, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wd, input bit do_check);
        logic [63:0] exp_rd;
        bit e;
        int idx, lat, busy_n;
        e      = exp_err(addr);
        idx    = widx(addr);
        exp_rd = e ? 64'd0 : model[idx];
        if (wr && !e) model[idx] = wd;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_wdata   = wd;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!bus.resp_valid && lat < 40) begin
            if (bus.busy) busy_n++;
            @(posedge clock); #1;
            lat++;
        end
        if (bus.busy) busy_n++;
        check({tag, "/latency"}, 64'(lat), 64'(WS + 1));
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(WS + 1));
        if (do_check) check({tag, "/rdata"}, bus.resp_rdata, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
        check({tag, "/error"}, 64'(bus.resp_error), 64'(e));
`endif
        @(posedge clock); #1;
        if (do_check) begin
            check({tag, "/idle_valid"}, 64'(bus.resp_valid), 64'd0);
            check({tag, "/hold"}, bus.resp_rdata, exp_rd);
        end
    endtask

    task automatic drive0(input int k);
        bus0.req_valid = 1'b1;
        if (k < 10) begin
            bus0.req_write   = 1'b1;
            bus0.req_address = 64'(k) << 3;
            bus0.req_wdata   = 64'hC0DE_0000 + 64'(k);
            model0[k]        = 64'hC0DE_0000 + 64'(k);
        end else begin
            bus0.req_write   = 1'b0;
            bus0.req_address = 64'(k - 10) << 3;
            bus0.req_wdata   = 64'd0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, acc_n, resp_n, idx, r, k, cyc, nresp, first_ld, last_ld;
        bit acc;
        logic [63:0] a, d;

        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_address = '0;  bus.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_address = '0; bus0.req_wdata = '0;

        #6;
        check("rst/req_ready",  64'(bus.req_ready), 64'd1);
        check("rst/resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst/busy",       64'(bus.busy), 64'd0);
        check("rst/resp_rdata", bus.resp_rdata, 64'd0);
        check("rst0/req_ready", 64'(bus0.req_ready), 64'd1);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (!(bus.req_ready === 1'b1 && bus.resp_valid === 1'b0 &&
                  bus.busy === 1'b0 && bus.resp_rdata === 64'd0)) bad++;
        end
        check("idle20/changes", 64'(bad), 64'd0);

        for (int i = 0; i < DEPTH; i++) xact("fill", 1'b1, 64'(i) << 3, {$urandom, $urandom}, 1'b0);

        xact("st18",  1'b1, 64'h18,  64'h0000_0000_DEAD_BEEF, 1'b1);
        xact("ld18",  1'b0, 64'h18,  64'd0, 1'b1);
        check("ld18/value", model[3], 64'h0000_0000_DEAD_BEEF);
        xact("st40a", 1'b1, 64'h40,  64'h1111, 1'b1);
        xact("st40b", 1'b1, 64'h40,  64'h2222, 1'b1);
        xact("ld40",  1'b0, 64'h40,  64'd0, 1'b1);
        xact("st808", 1'b1, 64'h808, 64'hABCD, 1'b1);
        xact("ld008", 1'b0, 64'h008, 64'd0, 1'b1);

        // Request held high through the whole transaction: exactly one acceptance and one response.
        idx = widx(64'h60);
        d   = model[idx];
        model[idx] = 64'h6060;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 64'h60; bus.req_wdata = 64'h6060;
        acc_n = 0; resp_n = 0;
        for (int c = 0; c < WS + 6; c++) begin
            if (bus.req_valid && bus.req_ready) acc_n++;
            if (bus.resp_valid) begin
                resp_n++;
                check("hold/old_word", bus.resp_rdata, d);
                bus.req_valid = 1'b0;
            end
            @(posedge clock); #1;
        end
        check("hold/acceptances", 64'(acc_n), 64'd1);
        check("hold/responses",   64'(resp_n), 64'd1);
        xact("hold/ld60", 1'b0, 64'h60, 64'd0, 1'b1);

        // Reset while the store to 0x20 is waiting: nothing commits, no response.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 64'h20; bus.req_wdata = 64'h5555;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        check("rstwait/busy_before", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rstwait/busy",       64'(bus.busy), 64'd0);
        check("rstwait/req_ready",  64'(bus.req_ready), 64'd1);
        check("rstwait/resp_rdata", bus.resp_rdata, 64'd0);
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        resp_n = 0;
        repeat (6) begin
            if (bus.resp_valid) resp_n++;
            @(posedge clock); #1;
        end
        check("rstwait/no_resp", 64'(resp_n), 64'd0);
        xact("rstwait/ld20", 1'b0, 64'h20, 64'd0, 1'b1);

        for (int t = 0; t < 80; t++) begin
            idx = $urandom_range(0, 15);
            a = 64'(idx) << 3;
            if ($urandom_range(0, 3) == 0) a[2:0] = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 40);
                a[AB + 3 + r] = 1'b1;
            end
            xact("rand", 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'b1);
        end

        // Zero wait states: 10 stores then 10 loads streamed with req_valid held high.
        k = 0; cyc = 0; nresp = 0; first_ld = 0; last_ld = 0;
        drive0(k);
        while (nresp < 20 && cyc < 100) begin
            acc = bus0.req_valid && bus0.req_ready;
            @(posedge clock); #1;
            cyc++;
            if (acc) check("ws0/resp_next_cycle", 64'(bus0.resp_valid), 64'd1);
            if (bus0.resp_valid) begin
                if (nresp >= 10) check("ws0/load", bus0.resp_rdata, model0[nresp - 10]);
                if (nresp == 10) first_ld = cyc;
                if (nresp == 19) last_ld = cyc;
                nresp++;
            end
            if (acc) begin
                k++;
                if (k < 20) drive0(k);
                else bus0.req_valid = 1'b0;
            end
        end
        check("ws0/responses", 64'(nresp), 64'd20);
        check("ws0/load_span", 64'(last_ld - first_ld), 64'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
